bpsk_packet_receiver: RTL and testbench

//  Receive-side counterpart of the Modulator: takes symbol-rate IQ samples (I in [31:16], Q in [15:0]),

---
 rtl/rx_pkg.sv | 35 +++
 rtl/preamble_correlator.sv | 58 +++++
 rtl/bpsk_packet_receiver.sv | 168 ++++++++++++++++
 tb/tb_bpsk_packet_receiver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared constants, FSM state type and popcount helper for the BPSK packet receiver.
// The optional inverted-preamble match is enabled by defining PREAMBLE_INVERT_EN.
package rx_pkg;

    localparam int SIZE_INPUT_BIT  = 32;
    localparam int SIZE_QI         = 16;
    localparam int SIZE_OUTPUT_BIT = 8;
    localparam int SIZE_BIT_PACK   = 1976;
    localparam int SIZE_PREAMBLE   = 32;

    localparam logic [SIZE_PREAMBLE-1:0] PREAMBLE = 32'h1ACFFC1D;
    localparam logic [5:0]               MAX_ERR  = 6'd2;

    localparam int SIZE_PAYLOAD = SIZE_BIT_PACK - SIZE_PREAMBLE;
    localparam int NUM_BYTES    = SIZE_PAYLOAD / SIZE_OUTPUT_BIT;
    localparam int BIT_CNT_W    = $clog2(SIZE_PAYLOAD);

    localparam logic [5:0]           FILL_FULL = 6'(SIZE_PREAMBLE);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(SIZE_PAYLOAD - 1);

    typedef enum logic {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } rx_state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/preamble_correlator.sv
// Sliding 32-bit window of hard-decided bits with a saturating fill counter; flags a
// preamble match (and, with PREAMBLE_INVERT_EN, an inverted-preamble match).
module preamble_correlator
    import rx_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic valid_i,
    input  logic bit_i,
    input  logic clear_i,
    output logic match_o
`ifdef PREAMBLE_INVERT_EN
    ,
    output logic match_inv_o
`endif
);

    logic [SIZE_PREAMBLE-1:0] window_q, window_d;
    logic [5:0]               fill_q, fill_d;
    logic                     shift;
    logic                     full_d;

    always_comb begin
        shift    = en_i && valid_i;
        window_d = window_q;
        fill_d   = fill_q;
        if (shift) begin
            window_d = {window_q[SIZE_PREAMBLE-2:0], bit_i};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 6'd1;
            end
        end
        if (clear_i) begin
            window_d = '0;
            fill_d   = '0;
        end
    end

    // Match is judged on the window including the sample arriving now, so the
    // very next valid sample is already the first payload bit.
    assign full_d  = shift && !clear_i && (fill_d == FILL_FULL);
    assign match_o = full_d && (popcount32(window_d ^ PREAMBLE) <= MAX_ERR);
`ifdef PREAMBLE_INVERT_EN
    assign match_inv_o = full_d && (popcount32(window_d ^ ~PREAMBLE) <= MAX_ERR);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/bpsk_packet_receiver.sv
// BPSK hard-decision packet receiver: preamble search, then MSB-first byte packing onto a
// valid/ready stream. Defining PREAMBLE_INVERT_EN also accepts 180-degree-rotated packets.
module bpsk_packet_receiver
    import rx_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]  i_data,
    input  logic                       i_valid_input,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid_output,
    input  logic                       i_ready,
    output logic                       o_sync,
    output logic                       o_last,
    output logic                       o_overflow
`ifdef PREAMBLE_INVERT_EN
    ,
    output logic                       o_inverted
`endif
);

    // Output stream: o_valid_output/o_data/o_last form a register stage; a byte moves on
    // when o_valid_output && i_ready at a clock edge and is held unchanged otherwise.

    rx_state_t                  state_q, state_d;
    logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]                 sr_q, sr_d;
    logic [SIZE_OUTPUT_BIT-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       last_q, last_d;
    logic                       sync_q, sync_d;
    logic                       ovf_q, ovf_d;

    logic                       rx_bit;
    logic                       pay_bit;
    logic                       match;
    logic                       found;
    logic                       pkt_end;
    logic                       byte_done;
    logic [SIZE_OUTPUT_BIT-1:0] new_byte;
    logic                       unused_iq;

    // I sits in [31:16]; its sign bit is the hard decision, Q is not used.
    assign rx_bit    = i_data[SIZE_INPUT_BIT-1];
    assign unused_iq = ^i_data[SIZE_INPUT_BIT-2:0];

`ifdef PREAMBLE_INVERT_EN
    logic inv_q, inv_d;
    logic match_inv;
    assign found   = match || match_inv;
    assign pay_bit = rx_bit ^ inv_q;
`else
    assign found   = match;
    assign pay_bit = rx_bit;
`endif

    assign new_byte = {sr_q, pay_bit};

    preamble_correlator u_corr (
        .clk_i       (i_clk),
        .rst_n_i     (i_reset),
        .en_i        (state_q == SEARCH),
        .valid_i     (i_valid_input),
        .bit_i       (rx_bit),
        .clear_i     (pkt_end),
        .match_o     (match)
`ifdef PREAMBLE_INVERT_EN
        ,
        .match_inv_o (match_inv)
`endif
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        sync_d    = 1'b0;
        ovf_d     = 1'b0;
        pkt_end   = 1'b0;
        byte_done = 1'b0;
`ifdef PREAMBLE_INVERT_EN
        inv_d     = inv_q;
`endif

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            SEARCH: begin
                if (found) begin
                    state_d   = PAYLOAD;
                    sync_d    = 1'b1;
                    bit_cnt_d = '0;
`ifdef PREAMBLE_INVERT_EN
                    inv_d     = !match;
`endif
                end
            end
            PAYLOAD: begin
                if (i_valid_input) begin
                    sr_d      = new_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    byte_done = (bit_cnt_q[2:0] == 3'b111);
                    if (bit_cnt_q == LAST_BIT) begin
                        pkt_end   = 1'b1;
                        state_d   = SEARCH;
                        bit_cnt_d = '0;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        // A byte completing while the held one is stuck is dropped, never overwritten.
        if (byte_done) begin
            if (!valid_q || i_ready) begin
                data_d  = new_byte;
                valid_d = 1'b1;
                last_d  = pkt_end;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= SEARCH;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            sync_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef PREAMBLE_INVERT_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            sync_q    <= sync_d;
            ovf_q     <= ovf_d;
`ifdef PREAMBLE_INVERT_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign o_data         = data_q;
    assign o_valid_output = valid_q;
    assign o_last         = last_q;
    assign o_sync         = sync_q;
    assign o_overflow     = ovf_q;
`ifdef PREAMBLE_INVERT_EN
    assign o_inverted     = inv_q;
`endif

endmodule

// File: tb/tb_bpsk_packet_receiver.sv
// Self-checking bench for bpsk_packet_receiver: table of whole-packet scenarios plus
// hand-written backpressure and mid-packet-reset sequences.
module tb_bpsk_packet_receiver;

    localparam logic [31:0] PRE   = 32'h1ACFFC1D;
    localparam logic [15:0] I_POS = 16'h1F40;  // +8000
    localparam logic [15:0] I_NEG = 16'hE0C0;  // -8000
    localparam int          NBYTE = 243;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_valid_input = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid_output;
    logic        i_ready = 1'b1;
    logic        o_sync;
    logic        o_last;
    logic        o_overflow;
`ifdef PREAMBLE_INVERT_EN
    logic        o_inverted;
`endif

    bpsk_packet_receiver dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_data         (i_data),
        .i_valid_input  (i_valid_input),
        .o_data         (o_data),
        .o_valid_output (o_valid_output),
        .i_ready        (i_ready),
        .o_sync         (o_sync),
        .o_last         (o_last),
        .o_overflow     (o_overflow)
`ifdef PREAMBLE_INVERT_EN
        ,
        .o_inverted     (o_inverted)
`endif
    );

    always #5 i_clk = ~i_clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         sync_cnt = 0;
    int         ovf_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];
    logic       rcv_last_q[$];
    logic       held = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: collects handshaken bytes, counts pulses, checks held bytes stay put.
    always @(negedge i_clk) begin
        if (o_sync) sync_cnt++;
        if (o_overflow) ovf_cnt++;
        if (o_valid_output) begin
            if (held) begin
                check("hold_data", {24'd0, o_data}, {24'd0, held_data});
                check("hold_last", {31'd0, o_last}, {31'd0, held_last});
            end
            if (i_ready) begin
                rcv_q.push_back(o_data);
                rcv_last_q.push_back(o_last);
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = o_data;
                held_last = o_last;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic do_reset(input int id);
        @(posedge i_clk); #1;
        i_reset       = 1'b0;
        i_valid_input = 1'b0;
        i_ready       = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check($sformatf("r%0d rst_data", id), {24'd0, o_data}, 32'd0);
        check($sformatf("r%0d rst_valid", id), {31'd0, o_valid_output}, 32'd0);
        check($sformatf("r%0d rst_sync", id), {31'd0, o_sync}, 32'd0);
        check($sformatf("r%0d rst_last", id), {31'd0, o_last}, 32'd0);
        check($sformatf("r%0d rst_ovf", id), {31'd0, o_overflow}, 32'd0);
`ifdef PREAMBLE_INVERT_EN
        check($sformatf("r%0d rst_inv", id), {31'd0, o_inverted}, 32'd0);
`endif
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        sync_cnt = 0;
        ovf_cnt  = 0;
        rcv_q.delete();
        rcv_last_q.delete();
    endtask

    task automatic send_sym(input logic b, input logic inv, input int gap, input logic rdy);
        logic [15:0] ival;
        @(posedge i_clk); #1;
        ival          = (b ^ inv) ? I_NEG : I_POS;
        i_data        = {ival, 16'($urandom_range(0, 65535))};
        i_valid_input = 1'b1;
        i_ready       = rdy;
        for (int g = 0; g < gap; g++) begin
            @(posedge i_clk); #1;
            i_valid_input = 1'b0;
            i_data        = 32'($urandom_range(0, 32'hFFFF_FFFF));
        end
    endtask

    task automatic idle(input int n);
        @(posedge i_clk); #1;
        i_valid_input = 1'b0;
        i_ready       = 1'b1;
        repeat (n) @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Preamble then payload bytes 0x00..0xF2 MSB first; stops after max_bits payload bits.
    // With bp set, i_ready is low while payload bits 44..67 are on the input.
    task automatic send_packet(input logic [31:0] pre, input logic inv, input int gap,
                               input logic bp, input int max_bits);
        logic [7:0] b;
        int         idx;
        for (int i = 31; i >= 0; i--) send_sym(pre[i], inv, gap, 1'b1);
        for (int k = 0; k < NBYTE; k++) begin
            b = 8'(k);
            for (int j = 7; j >= 0; j--) begin
                idx = k * 8 + (7 - j);
                if (idx < max_bits) begin
                    send_sym(b[j], inv, gap, !(bp && idx >= 44 && idx < 68));
                end
            end
        end
    endtask

    task automatic check_packet(input int id, input int exp_sync, input int exp_ovf);
        int n;
        int lc;
        check($sformatf("v%0d sync_count", id), 32'(sync_cnt), 32'(exp_sync));
        check($sformatf("v%0d byte_count", id), 32'(rcv_q.size()), 32'(exp_q.size()));
        check($sformatf("v%0d ovf_count", id), 32'(ovf_cnt), 32'(exp_ovf));
        lc = 0;
        foreach (rcv_last_q[i]) if (rcv_last_q[i]) lc++;
        check($sformatf("v%0d last_count", id), 32'(lc), (exp_q.size() > 0) ? 32'd1 : 32'd0);
        if (rcv_last_q.size() > 0 && exp_q.size() > 0)
            check($sformatf("v%0d last_on_final", id), {31'd0, rcv_last_q[rcv_last_q.size()-1]}, 32'd1);
        n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("v%0d byte%0d", id, i), {24'd0, rcv_q[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic fill_exp(input logic full);
        exp_q.delete();
        if (full) for (int k = 0; k < NBYTE; k++) exp_q.push_back(8'(k));
    endtask

    typedef struct {
        logic [31:0] pre;
        logic        inv;
        int          gap;
        int          exp_sync;
        logic        exp_pkt;
        logic        exp_inv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{PRE,                 1'b0, 0, 1, 1'b1, 1'b0};  // clean
        vecs[1] = '{PRE ^ 32'h0400_0200, 1'b0, 0, 1, 1'b1, 1'b0};  // 2 flipped bits
        vecs[2] = '{PRE ^ 32'h8001_0001, 1'b0, 0, 0, 1'b0, 1'b0};  // 3 flipped bits
        vecs[3] = '{PRE,                 1'b0, 2, 1, 1'b1, 1'b0};  // valid every 3rd cycle
`ifdef PREAMBLE_INVERT_EN
        vecs[4] = '{PRE,                 1'b1, 0, 1, 1'b1, 1'b1};  // sign-inverted packet
`else
        vecs[4] = '{PRE,                 1'b1, 0, 0, 1'b0, 1'b0};
`endif

        for (int v = 0; v < 5; v++) begin
            do_reset(v);
            send_packet(vecs[v].pre, vecs[v].inv, vecs[v].gap, 1'b0, 1944);
            idle(20);
            fill_exp(vecs[v].exp_pkt);
            check_packet(v, vecs[v].exp_sync, 0);
`ifdef PREAMBLE_INVERT_EN
            check($sformatf("v%0d inverted", v), {31'd0, o_inverted}, {31'd0, vecs[v].exp_inv});
`endif
        end

        // Backpressure: byte 5 held, bytes 6 and 7 dropped with two overflow pulses.
        do_reset(10);
        send_packet(PRE, 1'b0, 0, 1'b1, 1944);
        idle(20);
        fill_exp(1'b1);
        exp_q.delete(7);
        exp_q.delete(6);
        check_packet(10, 1, 2);

        // Reset in the middle of byte 100, then a full clean packet.
        do_reset(11);
        send_packet(PRE, 1'b0, 0, 1'b0, 804);
        do_reset(12);
        send_packet(PRE, 1'b0, 0, 1'b0, 1944);
        idle(20);
        fill_exp(1'b1);
        check_packet(12, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
